// File: rtl/vga_sprite_engine.sv
// Sprite position/coverage stage between vga_sync and vga_graphs: takes one move
// command per frame and applies it during vertical blanking so frames never tear.
module vga_sprite_engine #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int SPRITE_W = 32,
  parameter int SPRITE_H = 32,
  parameter int STEP     = 2,
  parameter int X_INIT   = 304,
  parameter int Y_INIT   = 224
) (
  input  logic       clock_25,
  input  logic       reset,
  input  logic       display_on,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  input  logic       cmd_valid,
  input  logic [1:0] cmd_dir,
  output logic       cmd_ready,
  output logic       frame_tick,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       sprite_on,
  output logic [9:0] sprite_u,
  output logic [9:0] sprite_v
);

  typedef enum logic [1:0] {IDLE, PEND, UPDATE} state_t;

  localparam logic [10:0] L_STEP = 11'(STEP);
  localparam logic [9:0]  L_XMAX = 10'(H_ACTIVE - SPRITE_W);
  localparam logic [9:0]  L_YMAX = 10'(V_ACTIVE - SPRITE_H);

  state_t      r_state;
  state_t      w_stateNext;
  logic [1:0]  r_rstSync;
  logic [1:0]  r_cmdDir;
  logic        r_frameTick;
  logic [9:0]  r_posX;
  logic [9:0]  r_posY;
  logic        r_spriteOn;
  logic [9:0]  r_spriteU;
  logic [9:0]  r_spriteV;
  logic        w_accept;
  logic        w_apply;
  logic        w_tickDecode;
  logic [10:0] w_xExt;
  logic [10:0] w_yExt;
  logic [10:0] w_xSum;
  logic [10:0] w_ySum;
  logic [9:0]  w_xLeft;
  logic [9:0]  w_xRight;
  logic [9:0]  w_yUp;
  logic [9:0]  w_yDown;
  logic        w_inX;
  logic        w_inY;
  logic        w_hit;

  // Reset release is held off two clocks so the FSM never leaves IDLE on a metastable edge
  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) r_rstSync <= 2'b00;
    else        r_rstSync <= {r_rstSync[0], 1'b1};
  end

  assign w_tickDecode = (pixel_y == 10'(V_ACTIVE)) && (pixel_x == 10'd0);

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_cmdDir    <= 2'd0;
      r_frameTick <= 1'b0;
    end else begin
      r_state     <= w_stateNext;
      r_frameTick <= w_tickDecode;
      if (w_accept) r_cmdDir <= cmd_dir;
    end
  end

  always_comb begin
    w_stateNext = r_state;
    w_accept    = 1'b0;
    w_apply     = 1'b0;
    case (r_state)
      IDLE: begin
        if (cmd_valid && r_rstSync[1]) begin
          w_accept    = 1'b1;
          w_stateNext = PEND;
        end
      end
      PEND:    if (r_frameTick) w_stateNext = UPDATE;
      UPDATE: begin
        w_apply     = 1'b1;
        w_stateNext = IDLE;
      end
      default: w_stateNext = IDLE;
    endcase
  end

  // Saturating moves are evaluated one bit wider so the edges clamp instead of wrapping
  assign w_xExt   = {1'b0, r_posX};
  assign w_yExt   = {1'b0, r_posY};
  assign w_xSum   = w_xExt + L_STEP;
  assign w_ySum   = w_yExt + L_STEP;
  assign w_xLeft  = (w_xExt < L_STEP) ? 10'd0 : 10'(w_xExt - L_STEP);
  assign w_yUp    = (w_yExt < L_STEP) ? 10'd0 : 10'(w_yExt - L_STEP);
  assign w_xRight = (w_xSum > {1'b0, L_XMAX}) ? L_XMAX : w_xSum[9:0];
  assign w_yDown  = (w_ySum > {1'b0, L_YMAX}) ? L_YMAX : w_ySum[9:0];

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_posX <= 10'(X_INIT);
      r_posY <= 10'(Y_INIT);
    end else if (w_apply) begin
      case (r_cmdDir)
        2'd0:    r_posX <= w_xLeft;
        2'd1:    r_posX <= w_xRight;
        2'd2:    r_posY <= w_yUp;
        default: r_posY <= w_yDown;
      endcase
    end
  end

  assign w_inX = ({1'b0, pixel_x} >= w_xExt) && ({1'b0, pixel_x} < (w_xExt + 11'(SPRITE_W)));
  assign w_inY = ({1'b0, pixel_y} >= w_yExt) && ({1'b0, pixel_y} < (w_yExt + 11'(SPRITE_H)));
  assign w_hit = display_on && w_inX && w_inY;

  always_ff @(posedge clock_25 or negedge reset) begin
    if (!reset) begin
      r_spriteOn <= 1'b0;
      r_spriteU  <= 10'd0;
      r_spriteV  <= 10'd0;
    end else begin
      r_spriteOn <= w_hit;
      r_spriteU  <= w_hit ? (pixel_x - r_posX) : 10'd0;
      r_spriteV  <= w_hit ? (pixel_y - r_posY) : 10'd0;
    end
  end

  assign cmd_ready  = (r_state == IDLE);
  assign frame_tick = r_frameTick;
  assign pos_x      = r_posX;
  assign pos_y      = r_posY;
  assign sprite_on  = r_spriteOn;
  assign sprite_u   = r_spriteU;
  assign sprite_v   = r_spriteV;

endmodule

// File: tb/tb_vga_sprite_engine.sv
// Self-checking bench for vga_sprite_engine: directed scenarios plus randomized
// short frames, compared every cycle against a behavioural model.
module tb_vga_sprite_engine;

  logic       clock_25;
  logic       reset;
  logic       display_on;
  logic [9:0] pixel_x;
  logic [9:0] pixel_y;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic       cmd_ready;
  logic       frame_tick;
  logic [9:0] pos_x;
  logic [9:0] pos_y;
  logic       sprite_on;
  logic [9:0] sprite_u;
  logic [9:0] sprite_v;

  int  checks = 0;
  int  errors = 0;
  bit  checkEn = 0;

  int  mX, mY, mU, mV, mDir;
  bit  mPending, mApplyNext, mTick, mOn;

  vga_sprite_engine dut (
    .clock_25  (clock_25),
    .reset     (reset),
    .display_on(display_on),
    .pixel_x   (pixel_x),
    .pixel_y   (pixel_y),
    .cmd_valid (cmd_valid),
    .cmd_dir   (cmd_dir),
    .cmd_ready (cmd_ready),
    .frame_tick(frame_tick),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
    .sprite_on (sprite_on),
    .sprite_u  (sprite_u),
    .sprite_v  (sprite_v)
  );

  initial begin
    clock_25 = 0;
    forever #20 clock_25 = ~clock_25;
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference: a command outstanding blocks new ones; the first tick seen while it
  // is outstanding moves the sprite two clocks after that tick.
  always @(posedge clock_25 or negedge reset) begin : model
    int px, py;
    if (!reset) begin
      mX = 304; mY = 224; mU = 0; mV = 0; mDir = 0;
      mPending = 0; mApplyNext = 0; mTick = 0; mOn = 0;
    end else begin
      px  = int'(pixel_x);
      py  = int'(pixel_y);
      mOn = display_on && px >= mX && px < mX + 32 && py >= mY && py < mY + 32;
      mU  = mOn ? px - mX : 0;
      mV  = mOn ? py - mY : 0;
      if (mApplyNext) begin
        case (mDir)
          0: mX = (mX < 2) ? 0 : mX - 2;
          1: mX = (mX + 2 > 608) ? 608 : mX + 2;
          2: mY = (mY < 2) ? 0 : mY - 2;
          default: mY = (mY + 2 > 448) ? 448 : mY + 2;
        endcase
        mPending   = 0;
        mApplyNext = 0;
      end else if (mPending && mTick) begin
        mApplyNext = 1;
      end else if (!mPending && cmd_valid) begin
        mPending = 1;
        mDir     = int'(cmd_dir);
      end
      mTick = (py == 480) && (px == 0);
    end
  end

  always @(negedge clock_25) begin
    if (checkEn) begin
      checkOutput("cmd_ready",  int'(cmd_ready),  int'(!mPending));
      checkOutput("frame_tick", int'(frame_tick), int'(mTick));
      checkOutput("pos_x",      int'(pos_x),      mX);
      checkOutput("pos_y",      int'(pos_y),      mY);
      checkOutput("sprite_on",  int'(sprite_on),  int'(mOn));
      checkOutput("sprite_u",   int'(sprite_u),   mU);
      checkOutput("sprite_v",   int'(sprite_v),   mV);
    end
  end

  task automatic applyStimulus(input int px, input int py, input bit disp,
                               input bit valid, input int dir);
    pixel_x    = 10'(px);
    pixel_y    = 10'(py);
    display_on = disp;
    cmd_valid  = valid;
    cmd_dir    = 2'(dir);
    @(negedge clock_25);
  endtask

  task automatic randPixel(output int px, output int py, output bit disp);
    int mode;
    mode = int'($urandom_range(0, 2));
    if (mode == 0) begin
      px   = mX - 3 + int'($urandom_range(0, 37));
      py   = mY - 3 + int'($urandom_range(0, 37));
      px   = (px < 0) ? 0 : (px > 639 ? 639 : px);
      py   = (py < 0) ? 0 : (py > 479 ? 479 : py);
      disp = ($urandom_range(0, 7) != 0);
    end else if (mode == 1) begin
      px   = int'($urandom_range(0, 639));
      py   = int'($urandom_range(0, 479));
      disp = 1;
    end else begin
      px   = int'($urandom_range(1, 799));
      py   = int'($urandom_range(481, 524));
      disp = 0;
    end
  endtask

  // validMode: 0 = no commands, 1 = always offer dir, 2 = random valid/dir
  task automatic runFrames(input int n, input int validMode, input int dir);
    int px, py, d;
    bit disp, v;
    for (int f = 0; f < n; f++) begin
      for (int c = 0; c < 8; c++) begin
        randPixel(px, py, disp);
        if (c == 7) begin px = 0; py = 480; disp = 0; end
        v = (validMode == 1) || (validMode == 2 && $urandom_range(0, 1) == 1);
        d = (validMode == 2) ? int'($urandom_range(0, 3)) : dir;
        applyStimulus(px, py, disp, v, d);
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(100, 100, 0, 0, 0);
  endtask

  initial begin
    reset = 1; display_on = 0; pixel_x = 0; pixel_y = 0; cmd_valid = 0; cmd_dir = 0;
    #2 reset = 0;
    checkEn = 1;
    idle(3);
    checkOutput("rst_pos_x", int'(pos_x), 304);
    checkOutput("rst_ready", int'(cmd_ready), 1);
    #2 reset = 1;
    idle(4);
    checkOutput("rel_pos_x", int'(pos_x), 304);
    checkOutput("rel_pos_y", int'(pos_y), 224);
    checkOutput("rel_ready", int'(cmd_ready), 1);
    checkOutput("rel_sprite_on", int'(sprite_on), 0);
    checkOutput("rel_frame_tick", int'(frame_tick), 0);

    applyStimulus(304, 224, 1, 0, 0);
    checkOutput("cov_tl_on", int'(sprite_on), 1);
    checkOutput("cov_tl_u", int'(sprite_u), 0);
    checkOutput("cov_tl_v", int'(sprite_v), 0);
    applyStimulus(335, 255, 1, 0, 0);
    checkOutput("cov_br_on", int'(sprite_on), 1);
    checkOutput("cov_br_u", int'(sprite_u), 31);
    checkOutput("cov_br_v", int'(sprite_v), 31);
    applyStimulus(336, 224, 1, 0, 0);
    checkOutput("cov_right_edge", int'(sprite_on), 0);
    applyStimulus(310, 230, 0, 0, 0);
    checkOutput("cov_blank", int'(sprite_on), 0);

    applyStimulus(50, 100, 1, 1, 1);
    checkOutput("right_ready_low", int'(cmd_ready), 0);
    applyStimulus(0, 480, 0, 0, 0);
    checkOutput("right_tick", int'(frame_tick), 1);
    idle(2);
    checkOutput("right_pos_x", int'(pos_x), 306);
    checkOutput("right_pos_y", int'(pos_y), 224);
    checkOutput("right_ready", int'(cmd_ready), 1);

    applyStimulus(10, 100, 1, 1, 1);
    applyStimulus(20, 100, 1, 1, 3);
    checkOutput("bp_ready_low", int'(cmd_ready), 0);
    applyStimulus(0, 480, 0, 1, 3);
    applyStimulus(5, 481, 0, 1, 3);
    applyStimulus(6, 481, 0, 1, 3);
    checkOutput("bp_pos_x", int'(pos_x), 308);
    checkOutput("bp_pos_y", int'(pos_y), 224);
    checkOutput("bp_ready_back", int'(cmd_ready), 1);
    applyStimulus(7, 481, 0, 1, 3);
    checkOutput("bp_second_accept", int'(cmd_ready), 0);
    applyStimulus(0, 480, 0, 0, 0);
    idle(2);
    checkOutput("bp_pos_y_226", int'(pos_y), 226);

    applyStimulus(30, 100, 1, 1, 3);
    applyStimulus(31, 100, 1, 0, 0);
    #2 reset = 0;
    #1;
    checkOutput("mid_rst_pos_y", int'(pos_y), 224);
    checkOutput("mid_rst_ready", int'(cmd_ready), 1);
    @(negedge clock_25);
    #2 reset = 1;
    idle(4);
    runFrames(2, 0, 0);
    checkOutput("mid_rst_pos_y_after", int'(pos_y), 224);
    checkOutput("mid_rst_pos_x_after", int'(pos_x), 304);

    runFrames(60, 2, 0);
    runFrames(220, 1, 0);
    checkOutput("clamp_left", int'(pos_x), 0);
    runFrames(200, 1, 2);
    checkOutput("clamp_up", int'(pos_y), 0);
    runFrames(310, 1, 1);
    checkOutput("clamp_right", int'(pos_x), 608);
    runFrames(230, 1, 3);
    checkOutput("clamp_down", int'(pos_y), 448);
    idle(3);

    checkEn = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vga_sprite_engine.md
# vga_sprite_engine

Sprite position and coverage stage for the robot display. It sits between `vga_sync` and `vga_graphs`. It consumes the `pixel_x`/`pixel_y`/`display_on` scan stream and accepts one movement command per frame through a valid/ready handshake. Position updates only during vertical blanking, so a frame never tears. Every pixel gets a registered coverage flag and sprite-local coordinates for `vga_graphs` to colour.

## Interface
- `H_ACTIVE`, 640: visible pixels per line.
- `V_ACTIVE`, 480: visible lines per frame.
- `SPRITE_W`, 32: sprite width in pixels.
- `SPRITE_H`, 32: sprite height in lines.
- `STEP`, 2: pixels moved per applied command.
- `X_INIT`, 304: reset x position (top-left corner).
- `Y_INIT`, 224: reset y position (top-left corner).
- `clock_25`  in  1  pixel clock, 25 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `display_on`  in  1  visible-region flag from `vga_sync`.
- `pixel_x`  in  10  current scan column from `vga_sync`.
- `pixel_y`  in  10  current scan line from `vga_sync`.
- `cmd_valid`  in  1  movement command offered.
- `cmd_dir`  in  2  direction: 0 = left, 1 = right, 2 = up, 3 = down.
- `cmd_ready`  out  1  command register empty; a command can be accepted.
- `frame_tick`  out  1  one-cycle pulse at the start of vertical blanking.
- `pos_x`  out  10  sprite top-left column.
- `pos_y`  out  10  sprite top-left line.
- `sprite_on`  out  1  registered: the current pixel lies inside the sprite.
- `sprite_u`  out  10  registered: `pixel_x - pos_x`; meaningful only when `sprite_on`=1.
- `sprite_v`  out  10  registered: `pixel_y - pos_y`; meaningful only when `sprite_on`=1.

## Operation
- **Reset values:**
  - `pos_x`=`X_INIT`, `pos_y`=`Y_INIT`.
  - `sprite_on`=0, `sprite_u`=0, `sprite_v`=0.
  - `frame_tick`=0, `cmd_ready`=1.
  - State = IDLE; the pending command is discarded.
- **Frame tick:** raised for exactly one cycle when `pixel_y`==`V_ACTIVE` and `pixel_x`==0. It is decoded combinationally and registered, so the pulse appears one cycle after that scan point.
- **State machine:**
  - IDLE: `cmd_ready`=1. On `cmd_valid`=1, latch `cmd_dir` and go to PEND.
  - PEND: `cmd_ready`=0. The command is held. On a registered `frame_tick`, go to UPDATE.
  - UPDATE (one cycle): apply the move, then return to IDLE.
- **Handshake:**
  - Transfer happens when `cmd_valid` and `cmd_ready` are both 1 on a rising edge.
  - A valid offered while `cmd_ready`=0 is ignored; the source must hold it.
  - A command accepted in the same cycle as `frame_tick` is applied at the following tick, not the current one.
- **Moves (saturating, computed in 11 bits to avoid wrap):**
  - Left: `pos_x` = `pos_x` < `STEP` ? 0 : `pos_x` - `STEP`.
  - Right: `pos_x` = min(`pos_x` + `STEP`, `H_ACTIVE` - `SPRITE_W`); maximum is 608.
  - Up: `pos_y` = `pos_y` < `STEP` ? 0 : `pos_y` - `STEP`.
  - Down: `pos_y` = min(`pos_y` + `STEP`, `V_ACTIVE` - `SPRITE_H`); maximum is 448.
- **Coverage:** `sprite_on` = `display_on` AND `pos_x` ≤ `pixel_x` < `pos_x` + `SPRITE_W` AND `pos_y` ≤ `pixel_y` < `pos_y` + `SPRITE_H`.
  - Comparisons use 11-bit sums.
  - When `sprite_on`=0, `sprite_u`/`sprite_v` are forced to 0.

## Timing
- `sprite_on`, `sprite_u`, `sprite_v` have 1-cycle latency from `pixel_x`/`pixel_y`/`display_on`. `vga_graphs` delays `h_sync`/`v_sync` by one stage to match.
- Command to position change: a command accepted at cycle t updates `pos_x`/`pos_y` 2 cycles after the next `frame_tick` pulse (tick → UPDATE → register). This always lands inside vertical blanking.
- `cmd_ready` falls on the cycle after acceptance and rises on the cycle after UPDATE.
- Throughput: at most one applied command per frame.
- Reset asserted mid-PEND or mid-UPDATE: all outputs return to reset values immediately (asynchronous). The command is lost and not applied after release.
- Reset deassertion is synchronised internally by a 2-flop release on `clock_25` before the state machine leaves IDLE.

## Test plan
- Reset check: hold `reset`=0, then release → `pos_x`=304, `pos_y`=224, `cmd_ready`=1, `sprite_on`=0, `frame_tick`=0.
- Right move: `cmd_valid`=1, `cmd_dir`=1 for one cycle at `pixel_y`=100 → `cmd_ready`=0; after `frame_tick`, `pos_x`=306 and `pos_y`=224; `cmd_ready` returns to 1.
- Left clamp: start with `X_INIT`=2, apply left on three consecutive frames → `pos_x` = 0, 0, 0, never 1022.
- Backpressure: offer cmd 1 then cmd 3 back-to-back → only cmd 1 is accepted; cmd 3 held with `cmd_ready`=0 until after the tick, then accepted and applied on the next frame (`pos_y`=226).
- Coverage, at reset position:
  - Scan pixel (304,224) with `display_on`=1 → next cycle `sprite_on`=1, `sprite_u`=0, `sprite_v`=0.
  - Pixel (335,255) → `sprite_on`=1, `sprite_u`=31, `sprite_v`=31.
  - Pixel (336,224) → `sprite_on`=0.
  - Any pixel with `display_on`=0 → `sprite_on`=0.
- Reset mid-operation: accept cmd 3, assert `reset` before the tick → `pos_y` stays 224 after release and across the next two frames.
